receiver: RTL and testbench
===========================

# receiver

Serial byte receiver for the two-wire clock/data link driven by the board's transmitter. It oversamples the incoming line clock and data on `clk_sys`, detects the start condition, and shifts in 8 data bits LSB-first on line-clock rising edges. It ignores the trailing ack/stop slots and presents each byte as a one-cycle `valid` pulse to the consuming logic, such as the command parser or the clock display.

## Interface
- `IDLE_CYCLES`, default 16: consecutive `clk_sys` cycles with both lines high required to arm for a new frame.
- `TIMEOUT_CYCLES`, default 4096: maximum `clk_sys` cycles between line-clock rising edges inside a frame before the frame is aborted.
- `clk_sys`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `clk_in`  in  1  line clock, asynchronous to `clk_sys`, idle high.
- `data_in`  in  1  line data, asynchronous to `clk_sys`, idle high.
- `data`  out  8  received byte; valid while `valid`=1 and held until the next byte.
- `valid`  out  1  one-cycle pulse, byte received.
- `error`  out  1  one-cycle pulse, frame aborted by timeout.
- `busy`  out  1  high from start detection until the byte is delivered or the frame is aborted.

## Operation
- Synchronisation:
  - `clk_in` and `data_in` each pass through a 2-flop synchroniser, then through a third delay flop.
  - `rise` = sync2 & ~sync3 on the clock line.
  - `dfall` = ~sync2 & sync3 on the data line.
  - Data is always taken from the data sync2 in the same cycle as the clock sync2, so both lines see the same pipeline delay.
- States:
  - S_ARM: an idle counter counts cycles where both sync2 values are 1, and clears whenever either is 0. At `IDLE_CYCLES` -> S_WAIT_START.
  - S_WAIT_START: `dfall` with clock sync2=1 -> S_RECV, with `bit_cnt`=0, timer=0, `busy`=1. A clock sync2 value of 0 before any start -> S_ARM, with no output.
  - S_RECV:
    - On `rise`: shift register <= {data sync2, shreg[7:1]}, `bit_cnt`++, timer cleared.
    - On the `rise` where `bit_cnt`=7: `data` <= the completed byte, `valid`=1 for one cycle, `busy`=0 -> S_ARM.
    - Timer increments every cycle without `rise`. At `TIMEOUT_CYCLES`: `error`=1 for one cycle, `busy`=0, `data` unchanged -> S_ARM.
- The ack/stop slots and any trailing clock pulses are absorbed by S_ARM, which waits for the line to be idle again.
- Counters:
  - Idle counter and timer are 16 bits and saturate; they never wrap.
  - `bit_cnt` is 3 bits.
- Illegal state encoding -> S_ARM.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `error`=0, `busy`=0, state=S_ARM.
- Synchroniser and delay flops reset to 1, so reset never produces a false `rise` or `dfall`.
- Reset mid-frame discards the partial byte; no `valid` or `error` is produced for it.
- Reset has priority over every event in the same cycle.
- Latency: take edge E as the first `clk_sys` edge that samples `clk_in` high for bit 7.
  - `valid` and `data` update on edge E+2 and are visible for the cycle following it.
  - `busy` drops on the same edge.
- Start detection lags the line data fall by the same 2 edges.
- The line clock is supported when each phase is ≥3 `clk_sys` cycles and data is stable ≥2 `clk_sys` cycles around each line-clock rising edge. The transmitter guarantees this by changing data mid-low-phase.
- `valid` and `error` are never high in the same cycle.
- At least `IDLE_CYCLES`+1 cycles separate a `valid`/`error` pulse from the next `busy` rise.
- If `rise` and the timeout fall in the same cycle, `rise` wins and the timer clears.

## Test plan
- Reset then idle lines for 20 cycles, then transmitter frame 8'hA5 with `clk_in` period 16 -> exactly one `valid` pulse with `data`=8'hA5, `error` never high, `busy` low afterwards.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with ack/stop slots and 20 idle cycles between frames -> three `valid` pulses carrying those values in order.
- Start followed by 4 bits, then `clk_in` held low for 5000 cycles -> one `error` pulse 4096 cycles after the 4th `rise`, no `valid`, `data` keeps the previous byte; a following 8'h81 frame is received correctly.
- `reset` asserted for 1 cycle after 5 bits of 8'h5A, then a full 8'hC3 frame -> no output for 8'h5A, then `valid` with 8'hC3.
- `data_in` falls while lines have been idle only 10 cycles -> no start detected, `busy` stays 0. The same fall after 16 idle cycles -> `busy`=1 two edges after the fall.
- Measure latency on 8'h01 -> `valid` is visible exactly after edge E+2 relative to the `clk_sys` edge that first samples bit-7 `clk_in` high.

Source files
------------

// File: rtl/receiver.sv
// Serial byte receiver for the two-wire clock/data link: oversamples both lines on clk_sys,
// detects start (data fall with clock high) and shifts in 8 bits LSB-first on line-clock rises.
module receiver #(
    parameter int IDLE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       clk_in,
    input  logic       data_in,
    output logic [7:0] data,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_ARM        = 2'd0,
        S_WAIT_START = 2'd1,
        S_RECV       = 2'd2
    } state_t;

    localparam logic [15:0] IDLE_LIM    = 16'(IDLE_CYCLES);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    // [0]=sync1, [1]=sync2, [2]=delay flop; all preset to 1 so reset cannot fake an edge
    logic [2:0]  r_clk_sync;
    logic [2:0]  r_dat_sync;

    state_t      r_state;
    logic [15:0] r_idle_cnt;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shreg;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_error;
    logic        r_busy;

    state_t      w_state_next;
    logic [15:0] w_idle_next;
    logic [15:0] w_timer_next;
    logic [2:0]  w_bit_next;
    logic [7:0]  w_shreg_next;
    logic [7:0]  w_data_next;
    logic        w_valid_next;
    logic        w_error_next;
    logic        w_busy_next;

    logic        w_clk_s2;
    logic        w_dat_s2;
    logic        w_rise;
    logic        w_dfall;
    logic [15:0] w_idle_inc;
    logic [15:0] w_timer_inc;
    logic [7:0]  w_shifted;

    assign w_clk_s2    = r_clk_sync[1];
    assign w_dat_s2    = r_dat_sync[1];
    assign w_rise      = r_clk_sync[1] & ~r_clk_sync[2];
    assign w_dfall     = ~r_dat_sync[1] & r_dat_sync[2];
    assign w_idle_inc  = (r_idle_cnt == 16'hFFFF) ? r_idle_cnt : r_idle_cnt + 16'd1;
    assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;
    assign w_shifted   = {w_dat_s2, r_shreg[7:1]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 3'b111;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], clk_in};
            r_dat_sync <= {r_dat_sync[1:0], data_in};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= S_ARM;
            r_idle_cnt <= 16'd0;
            r_timer    <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shreg    <= 8'h00;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idle_cnt <= w_idle_next;
            r_timer    <= w_timer_next;
            r_bit_cnt  <= w_bit_next;
            r_shreg    <= w_shreg_next;
            r_data     <= w_data_next;
            r_valid    <= w_valid_next;
            r_error    <= w_error_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idle_next  = r_idle_cnt;
        w_timer_next = r_timer;
        w_bit_next   = r_bit_cnt;
        w_shreg_next = r_shreg;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_error_next = 1'b0;
        w_busy_next  = r_busy;
        case (r_state)
            S_ARM: begin
                w_busy_next = 1'b0;
                if (w_clk_s2 && w_dat_s2) begin
                    w_idle_next = w_idle_inc;
                    if (w_idle_inc >= IDLE_LIM) begin
                        w_state_next = S_WAIT_START;
                        w_idle_next  = 16'd0;
                    end
                end else begin
                    w_idle_next = 16'd0;
                end
            end
            S_WAIT_START: begin
                if (!w_clk_s2) begin
                    w_state_next = S_ARM;
                end else if (w_dfall) begin
                    w_state_next = S_RECV;
                    w_bit_next   = 3'd0;
                    w_timer_next = 16'd0;
                    w_busy_next  = 1'b1;
                end
            end
            S_RECV: begin
                // a rise in the same cycle as the timeout wins and restarts the timer
                if (w_rise) begin
                    w_shreg_next = w_shifted;
                    w_bit_next   = r_bit_cnt + 3'd1;
                    w_timer_next = 16'd0;
                    if (r_bit_cnt == 3'd7) begin
                        w_data_next  = w_shifted;
                        w_valid_next = 1'b1;
                        w_busy_next  = 1'b0;
                        w_state_next = S_ARM;
                    end
                end else begin
                    w_timer_next = w_timer_inc;
                    if (w_timer_inc >= TIMEOUT_LIM) begin
                        w_error_next = 1'b1;
                        w_busy_next  = 1'b0;
                        w_state_next = S_ARM;
                    end
                end
            end
            default: begin
                w_state_next = S_ARM;
                w_idle_next  = 16'd0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign data  = r_data;
    assign valid = r_valid;
    assign error = r_error;
    assign busy  = r_busy;

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: table of frames, hand-written corner sequences, and randomized frames
// checked against an expected-byte queue built from what the transmitter actually completed.
module tb_receiver;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       clk_in  = 1'b1;
    logic       data_in = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       error;
    logic       busy;

    receiver #(.IDLE_CYCLES(16), .TIMEOUT_CYCLES(4096)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clk_in  (clk_in),
        .data_in (data_in),
        .data    (data),
        .valid   (valid),
        .error   (error),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_mis = 0;

    // posedge counter; read at negedges only
    int pcyc = 0;
    initial forever begin
        @(posedge clk_sys);
        pcyc++;
    end

    logic [7:0] got_q[$];
    int   valid_cnt   = 0;
    int   error_cnt   = 0;
    int   both_cnt    = 0;
    int   last_valid_p = 0;
    int   last_error_p = 0;
    int   busy_fall_p  = 0;
    int   busy_rise_p  = 0;
    logic busy_prev    = 1'b0;

    initial forever begin
        @(negedge clk_sys);
        if (valid) begin
            got_q.push_back(data);
            valid_cnt++;
            last_valid_p = pcyc;
        end
        if (error) begin
            error_cnt++;
            last_error_p = pcyc;
        end
        if (valid && error) both_cnt++;
        if (busy_prev && !busy) busy_fall_p = pcyc;
        if (!busy_prev && busy) busy_rise_p = pcyc;
        busy_prev = busy;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic idle_lines(input int n);
        clk_in  = 1'b1;
        data_in = 1'b1;
        tick(n);
    endtask

    int last_rise_p = 0;

    // Transmitter: start = data fall with clock high; data changes mid-low-phase
    task automatic send_frame(input logic [7:0] b, input int half, input int nbits,
                              input bit do_start, input bit tail);
        logic [7:0] bv;
        bv = b;
        if (do_start) begin
            data_in = 1'b0;
            tick(half);
        end
        for (int i = 0; i < nbits; i++) begin
            clk_in = 1'b0;
            tick(half / 2);
            data_in = bv[i];
            tick(half - half / 2);
            clk_in = 1'b1;
            last_rise_p = pcyc;
            tick(half);
        end
        if (tail) begin
            clk_in = 1'b0;
            tick(half / 2);
            data_in = 1'b0;
            tick(half - half / 2);
            clk_in = 1'b1;
            tick(half);
            clk_in = 1'b0;
            tick(half);
            clk_in = 1'b1;
            tick(half / 2);
            data_in = 1'b1;
            tick(half - half / 2);
        end
    endtask

    typedef struct {
        logic [7:0] value;
        int         half;
        int         gap;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] exp_q[$];

    initial begin
        int n0, e0, d;
        logic [7:0] b;
        int half, gap, nb;

        tbl[0] = '{8'hA5, 8, 20};
        tbl[1] = '{8'h00, 8, 20};
        tbl[2] = '{8'hFF, 8, 20};
        tbl[3] = '{8'h3C, 8, 20};
        tbl[4] = '{8'h96, 4, 25};
        tbl[5] = '{8'h5B, 10, 30};

        reset = 1'b1;
        tick(3);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 0);
        check("reset_error", error, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        idle_lines(20);

        foreach (tbl[k]) begin
            n0 = valid_cnt;
            e0 = error_cnt;
            send_frame(tbl[k].value, tbl[k].half, 8, 1'b1, 1'b1);
            idle_lines(tbl[k].gap);
            check($sformatf("vec%0d_valid_count", k), valid_cnt - n0, 1);
            check($sformatf("vec%0d_data", k), got_q[$], tbl[k].value);
            check($sformatf("vec%0d_no_error", k), error_cnt - e0, 0);
            check($sformatf("vec%0d_busy_low", k), busy, 0);
        end

        // timeout: start + 4 bits, then line clock stuck low
        n0 = valid_cnt;
        e0 = error_cnt;
        send_frame(8'hE7, 8, 4, 1'b1, 1'b0);
        clk_in = 1'b0;
        tick(5000);
        d = last_error_p - (last_rise_p + 1);
        check("timeout_error_count", error_cnt - e0, 1);
        check("timeout_delay_window", (d >= 4096 && d <= 4102) ? 1 : 0, 1);
        check("timeout_no_valid", valid_cnt - n0, 0);
        check("timeout_data_held", data, tbl[5].value);
        check("timeout_busy_low", busy, 0);
        idle_lines(20);
        send_frame(8'h81, 8, 8, 1'b1, 1'b1);
        idle_lines(20);
        check("after_timeout_valid", valid_cnt - n0, 1);
        check("after_timeout_data", got_q[$], 8'h81);

        // reset mid-frame discards the partial byte
        n0 = valid_cnt;
        e0 = error_cnt;
        send_frame(8'h5A, 8, 5, 1'b1, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midreset_busy", busy, 0);
        idle_lines(20);
        check("midreset_no_valid", valid_cnt - n0, 0);
        send_frame(8'hC3, 8, 8, 1'b1, 1'b1);
        idle_lines(20);
        check("midreset_valid", valid_cnt - n0, 1);
        check("midreset_data", got_q[$], 8'hC3);
        check("midreset_no_error", error_cnt - e0, 0);

        // start after only 10 idle cycles is ignored
        n0 = busy_rise_p;
        clk_in = 1'b0;
        tick(4);
        clk_in  = 1'b1;
        data_in = 1'b1;
        tick(10);
        data_in = 1'b0;
        tick(6);
        check("short_idle_no_busy_rise", busy_rise_p - n0, 0);
        check("short_idle_busy", busy, 0);

        // start after exactly 16 idle cycles: busy two edges after the sampled fall
        clk_in = 1'b0;
        tick(4);
        clk_in  = 1'b1;
        data_in = 1'b1;
        tick(16);
        data_in = 1'b0;
        tick(2);
        check("start_busy_f1", busy, 0);
        tick(1);
        check("start_busy_f2", busy, 1);
        n0 = valid_cnt;
        tick(5);
        send_frame(8'h66, 8, 8, 1'b0, 1'b1);
        idle_lines(20);
        check("start16_valid", valid_cnt - n0, 1);
        check("start16_data", got_q[$], 8'h66);

        // latency on 8'h01: valid visible after edge E+2
        send_frame(8'h01, 8, 8, 1'b1, 1'b1);
        idle_lines(20);
        check("latency_valid_edge", last_valid_p - (last_rise_p + 1), 2);
        check("latency_busy_fall", busy_fall_p, last_valid_p);
        check("latency_data", got_q[$], 8'h01);

        // randomized frames, some aborted by reset
        got_q.delete();
        for (int r = 0; r < 24; r++) begin
            b    = 8'($urandom);
            half = $urandom_range(4, 10);
            gap  = $urandom_range(20, 40);
            if ($urandom_range(0, 4) == 0) begin
                nb = $urandom_range(1, 7);
                send_frame(b, half, nb, 1'b1, 1'b0);
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end else begin
                send_frame(b, half, 8, 1'b1, 1'b1);
                exp_q.push_back(b);
            end
            idle_lines(gap);
        end
        check("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);

        check("never_valid_and_error", both_cnt, 0);
        check("total_error_pulses", error_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
